// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write-back path: datapath
// widths, register-file geometry and the write-back arbiter priority type.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    // Which write-back source wins when both request in the same cycle.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    // Round-robin step: the winner of a completed grant drops to low
    // priority; with no grant the priority is left alone.
    function automatic prio_e prio_after(input logic won_a, input logic won_b, input prio_e cur);
        if (won_a) begin
            return PRIO_B;
        end
        if (won_b) begin
            return PRIO_A;
        end
        return cur;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register,
// set when a long-latency op issues and cleared when its result is written
// back. Provides the WAW issue stall and the RAW hazard lookup.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dest,
    output logic          issue_ready,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] chk_rs,
    input  logic [AW-1:0] chk_rt,
    output logic          hazard
);

    localparam int NR = 1 << AW;

    logic [NR-1:0] busy_reg;
    logic [NR-1:0] busy_next;
    logic          issue_fire;

    // A second op may not issue to a register that still has one in flight.
    assign issue_ready = rst_n & ~busy_reg[issue_dest];
    assign issue_fire  = issue_valid & issue_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_busy
            if (gi == ZERO_REG) begin : g_zero
                // $zero is never written, so it can never be pending.
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_fire & (issue_dest == AW'(gi));
                assign clr_hit = clr_valid & (clr_addr == AW'(gi));
                // Set and clear of the same bit cannot coincide: the issue
                // stall keeps a busy register from being re-issued.
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    // Busy vector register; reset forgets every in-flight destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // RAW hazard when either source of the decoding instruction is pending.
    assign hazard = busy_reg[chk_rs] | busy_reg[chk_rt];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between the ALU (A) and
// long-latency (B) write-back ports onto a single registered write port,
// plus a busy scoreboard for long-latency destinations.
module regfile_wb_arbiter #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] chk_rs,
    input  logic [ADDR_W-1:0] chk_rt,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    import mips_pkg::prio_e;
    import mips_pkg::PRIO_A;
    import mips_pkg::PRIO_B;
    import mips_pkg::prio_after;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(mips_pkg::ZERO_REG);

    prio_e             prio_reg;
    prio_e             prio_next;
    logic              grant_a;
    logic              grant_b;
    logic              rf_we_reg;
    logic              rf_we_next;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [ADDR_W-1:0] rf_waddr_next;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic [DATA_W-1:0] rf_wdata_next;

    // Grant decode: a lone requester always wins, a tie goes to the side
    // holding priority. Nothing is granted while reset is asserted.
    always_comb begin
        grant_a = rst_n & a_valid & (~b_valid | (prio_reg == PRIO_A));
        grant_b = rst_n & b_valid & (~a_valid | (prio_reg == PRIO_B));
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Priority next state: only a completed grant moves the pointer.
    always_comb begin
        prio_next = prio_after(grant_a, grant_b, prio_reg);
    end

    // Priority state register; A is favoured out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= PRIO_A;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // Write-port next state: writes to $zero are swallowed, and address/data
    // hold their last written value whenever no write is launched.
    always_comb begin
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (grant_a && (a_addr != ZERO_ADDR)) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = a_addr;
            rf_wdata_next = a_data;
        end else if (grant_b && (b_addr != ZERO_ADDR)) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = b_addr;
            rf_wdata_next = b_data;
        end
    end

    // Registered write port: one cycle from grant to register-file write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

    // Busy tracking: issues mark a destination, B write-backs release it.
    reg_scoreboard #(
        .AW(ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .clr_valid   (grant_b),
        .clr_addr    (b_addr),
        .chk_rs      (chk_rs),
        .chk_rt      (chk_rt),
        .hazard      (hazard)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts
// readies and hazard each cycle and queues the expected write-port value,
// which is popped and compared once the DUT has registered it.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          issue_valid, issue_ready;
    logic [AW-1:0] issue_dest, chk_rs, chk_rt;
    logic          hazard, rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_dest  (issue_dest),
        .chk_rs      (chk_rs),
        .chk_rt      (chk_rt),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [31:0]   busy_m;
    logic          prio_m;      // 0: A favoured, 1: B favoured
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy_m    = '0;
        prio_m    = 1'b0;
        last_addr = '0;
        last_data = '0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        a_valid     = 1'b0; a_addr = '0; a_data = '0;
        b_valid     = 1'b0; b_addr = '0; b_data = '0;
        issue_valid = 1'b0; issue_dest = '0;
        chk_rs      = '0;   chk_rt = '0;
    endtask

    // One clock of stimulus. Called at posedge+1; compares combinational
    // outputs at posedge+2 and the registered write port at the next posedge+1.
    task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input logic iv, input logic [AW-1:0] id,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        logic ga, gb, ir, hz;
        exp_t e;
        exp_t got_e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        issue_valid = iv; issue_dest = id;
        chk_rs = rs; chk_rt = rt;
        #1;
        ga = av && (!bv || (prio_m == 1'b0));
        gb = bv && (!av || (prio_m == 1'b1));
        ir = !busy_m[id];
        hz = busy_m[rs] | busy_m[rt];
        check("a_ready", 64'(a_ready), 64'(ga));
        check("b_ready", 64'(b_ready), 64'(gb));
        check("issue_ready", 64'(issue_ready), 64'(ir));
        check("hazard", 64'(hazard), 64'(hz));
        e.we   = (ga && aa != 0) || (gb && ba != 0);
        e.addr = last_addr;
        e.data = last_data;
        if (ga && aa != 0) begin
            e.addr = aa; e.data = ad;
        end else if (gb && ba != 0) begin
            e.addr = ba; e.data = bd;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (e.we) begin
            last_addr = e.addr;
            last_data = e.data;
        end
        if (gb) busy_m[ba] = 1'b0;
        if (iv && ir && id != 0) busy_m[id] = 1'b1;
        if (ga) prio_m = 1'b1;
        else if (gb) prio_m = 1'b0;
        if (ga) $display("[%0t] A write-back addr=%0d data=0x%08h", $time, aa, ad);
        if (gb) $display("[%0t] B write-back addr=%0d data=0x%08h", $time, ba, bd);
        if (iv && ir) $display("[%0t] issue dest=%0d", $time, id);
        #1;
        got_e = exp_q.pop_front();
        check("rf_we", 64'(rf_we), 64'(got_e.we));
        check("rf_waddr", 64'(rf_waddr), 64'(got_e.addr));
        check("rf_wdata", 64'(rf_wdata), 64'(got_e.data));
    endtask

    task automatic idle_cycle(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, rs, rt);
    endtask

    initial begin
        // Reset state with every requester active.
        rst_n = 1'b0;
        model_reset();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h2222_2222;
        issue_valid = 1'b1; issue_dest = 5'd3; chk_rs = 5'd3; chk_rt = 5'd4;
        #2;
        @(posedge clk);
        #1;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        check("rst_hazard", 64'(hazard), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention straight after reset: A, B, A, B.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'd1, 32'hA000_0000 + 32'(i), 1'b1, 5'd2, 32'hB000_0000 + 32'(i),
                  1'b0, '0, '0, '0);
        end

        // A alone, then an idle cycle where the write port must drop rf_we.
        cycle(1'b1, 5'd3, 32'h0000_1234, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        idle_cycle('0, '0);

        // Issue to 7, observe hazard, release through B.
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, '0);
        idle_cycle(5'd7, '0);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_DEAD, 1'b0, '0, 5'd7, '0);
        idle_cycle(5'd7, '0);

        // WAW stall on back-to-back issues to 7.
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, 5'd7);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, 5'd7);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, 5'd7);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_BEEF, 1'b1, 5'd7, '0, 5'd7);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, 5'd7);
        // Clear of 7 and issue of 9 in the same cycle both land.
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0777, 1'b1, 5'd9, 5'd7, 5'd9);
        idle_cycle(5'd7, 5'd9);
        cycle(1'b1, 5'd8, 32'h0000_0888, 1'b1, 5'd9, 32'h0000_0999, 1'b0, '0, '0, 5'd9);
        cycle(1'b1, 5'd8, 32'h0000_0888, 1'b1, 5'd9, 32'h0000_0999, 1'b0, '0, '0, 5'd9);
        idle_cycle('0, 5'd9);

        // $zero: write is handshaken but not performed; issue leaves no busy bit.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h0BAD_0BAD, 1'b1, 5'd0, 5'd0, 5'd0);
        idle_cycle(5'd0, 5'd0);

        // Randomised traffic over a small register window.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int r = 1; r < 8; r++) begin
            cycle(1'b0, '0, '0, 1'b1, AW'(r), 32'hC0DE_0000 + 32'(r), 1'b0, '0, '0, '0);
        end

        // Asynchronous reset with an issue to 5 and an A write in flight.
        cycle(1'b1, 5'd4, 32'h0000_5555, 1'b0, '0, '0, 1'b1, 5'd5, 5'd5, '0);
        idle_cycle(5'd5, '0);
        cycle(1'b1, 5'd4, 32'h0000_6666, 1'b0, '0, '0, 1'b0, '0, 5'd5, '0);
        a_valid = 1'b1;
        chk_rs  = 5'd5;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rf_we", 64'(rf_we), 64'd0);
        check("async_rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("async_rst_hazard", 64'(hazard), 64'd0);
        check("async_rst_a_ready", 64'(a_ready), 64'd0);
        check("async_rst_issue_ready", 64'(issue_ready), 64'd0);
        model_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle(5'd5, '0);
        cycle(1'b1, 5'd2, 32'h0000_2020, 1'b1, 5'd3, 32'h0000_3030, 1'b1, 5'd5, 5'd5, '0);
        cycle(1'b1, 5'd2, 32'h0000_2020, 1'b1, 5'd3, 32'h0000_3030, 1'b0, '0, 5'd5, '0);
        idle_cycle(5'd5, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
